// File: rtl/ysyx_22040750_muldiv_ctrl_pkg.sv
// ysyx_22040750_muldiv_ctrl_pkg: sequencer state encoding and I_op one-hot bit positions
package ysyx_22040750_muldiv_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;
    localparam int MD_MUL  = 0;
    localparam int MD_DIV  = 1;
    localparam int MD_DIVU = 2;
    localparam int MD_REM  = 3;
    localparam int MD_REMU = 4;
endpackage

// File: rtl/ysyx_22040750_muldiv_step.sv
// ysyx_22040750_muldiv_step: one iteration of shift-add multiply or restoring divide
module ysyx_22040750_muldiv_step #(
    parameter int XLEN = 64
) (
    input  logic            mul,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    input  logic [XLEN-1:0] z,
    output logic [XLEN-1:0] x_n,
    output logic [XLEN-1:0] y_n,
    output logic [XLEN-1:0] z_n
);
    logic [XLEN:0] diff;
    logic          borrow;
    // x is accumulator/remainder, y is multiplier/quotient, z is multiplicand/divisor
    always_comb begin
        diff   = {x, y[XLEN-1]} - {1'b0, z};
        borrow = diff[XLEN];
        x_n    = mul ? (y[0] ? x + z : x) : (borrow ? {x[XLEN-2:0], y[XLEN-1]} : diff[XLEN-1:0]);
        y_n    = mul ? y >> 1 : {y[XLEN-2:0], ~borrow};
        z_n    = mul ? z << 1 : z;
    end
endmodule

// File: rtl/ysyx_22040750_muldiv_ctrl.sv
// ysyx_22040750_muldiv_ctrl: iterative mul/div unit with valid/ready handshake and flush
module ysyx_22040750_muldiv_ctrl
    import ysyx_22040750_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            I_sys_clk,
    input  logic            I_rst_n,
    input  logic            I_valid,
    output logic            O_ready,
    input  logic [4:0]      I_op,
    input  logic            I_word,
    input  logic [XLEN-1:0] I_src1,
    input  logic [XLEN-1:0] I_src2,
    input  logic            I_flush,
    output logic            O_out_valid,
    input  logic            I_out_ready,
    output logic [XLEN-1:0] O_result,
    output logic            O_busy
);
    localparam int H = XLEN / 2;
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(H+1){1'b1}}, {(H-1){1'b0}}};

    state_t          state, state_n;
    logic [4:0]      op;
    logic            word, neg_q, neg_r;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] x, y, z, x_n, y_n, z_n;
    logic [XLEN-1:0] sa, sb, abs_a, abs_b, fast_res, q, r, sel;
    logic            is_mul, is_q, is_rem, is_signed, neg_a, neg_b, div0, ovf, fast;

    function automatic logic [XLEN-1:0] sext_w(input logic [H-1:0] v);
        return {{H{v[H-1]}}, v};
    endfunction

    assign is_mul      = op[MD_MUL];
    assign is_q        = op[MD_DIV] | op[MD_DIVU];
    assign is_rem      = op[MD_REM] | op[MD_REMU];
    assign is_signed   = op[MD_DIV] | op[MD_REM];
    assign O_ready     = state == S_IDLE;
    assign O_busy      = state != S_IDLE;
    assign O_out_valid = state == S_DONE;

    // Operand conditioning for PREP; y/z still hold the raw sources here
    always_comb begin
        sa       = word ? (is_signed ? sext_w(y[H-1:0]) : {{H{1'b0}}, y[H-1:0]}) : y;
        sb       = word ? (is_signed ? sext_w(z[H-1:0]) : {{H{1'b0}}, z[H-1:0]}) : z;
        neg_a    = is_signed & sa[XLEN-1];
        neg_b    = is_signed & sb[XLEN-1];
        abs_a    = neg_a ? -sa : sa;
        abs_b    = neg_b ? -sb : sb;
        div0     = sb == '0;
        ovf      = is_signed && sb == '1 && sa == (word ? MIN_W : MIN_D);
        fast     = !is_mul && (div0 || ovf);
        fast_res = div0 ? (is_q ? '1 : sa) : (is_rem ? '0 : sa);
        q        = neg_q ? -y : y;
        r        = neg_r ? -x : x;
        sel      = is_rem ? r : (is_q ? q : x);
    end

    always_comb begin
        state_n = state;
        if (I_flush)
            state_n = S_IDLE;
        else
            case (state)
                S_IDLE:  state_n = I_valid ? S_PREP : S_IDLE;
                S_PREP:  state_n = fast ? S_DONE : S_CALC;
                S_CALC:  state_n = cnt == CNT_W'(1) ? S_FIX : S_CALC;
                S_FIX:   state_n = S_DONE;
                S_DONE:  state_n = I_out_ready ? S_IDLE : S_DONE;
                default: state_n = S_IDLE;
            endcase
    end

    ysyx_22040750_muldiv_step #(.XLEN(XLEN)) u_step (
        .mul(is_mul),
        .x(x),
        .y(y),
        .z(z),
        .x_n(x_n),
        .y_n(y_n),
        .z_n(z_n)
    );

    always_ff @(posedge I_sys_clk) begin
        if (!I_rst_n) begin
            state    <= S_IDLE;
            op       <= '0;
            word     <= 1'b0;
            x        <= '0;
            y        <= '0;
            z        <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            O_result <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: if (I_valid && !I_flush) begin
                    op   <= I_op;
                    word <= I_word;
                    x    <= '0;
                    y    <= I_src1;
                    z    <= I_src2;
                end
                // Word dividends sit in the upper half so 32 shifts bring them through
                S_PREP: begin
                    x     <= '0;
                    y     <= is_mul ? sb : (word ? abs_a << H : abs_a);
                    z     <= is_mul ? sa : abs_b;
                    neg_q <= neg_a ^ neg_b;
                    neg_r <= neg_a;
                    cnt   <= word ? CNT_W'(H) : CNT_W'(XLEN);
                    if (fast)
                        O_result <= word ? sext_w(fast_res[H-1:0]) : fast_res;
                end
                S_CALC: begin
                    x   <= x_n;
                    y   <= y_n;
                    z   <= z_n;
                    cnt <= cnt - 1'b1;
                end
                S_FIX: O_result <= word ? sext_w(sel[H-1:0]) : sel;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040750_muldiv_ctrl.sv
// tb_ysyx_22040750_muldiv_ctrl: directed checks of results, latency, flush, backpressure, reset
module tb_ysyx_22040750_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        word = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  op = '0;
    logic [63:0] s1 = '0;
    logic [63:0] s2 = '0;
    logic        ready, out_valid, busy;
    logic [63:0] result;
    int          checks = 0;
    int          errors = 0;

    localparam logic [4:0] MUL = 5'b00001, DIV = 5'b00010, DIVU = 5'b00100, REM = 5'b01000, REMU = 5'b10000;

    ysyx_22040750_muldiv_ctrl dut (
        .I_sys_clk(clk),
        .I_rst_n(rst_n),
        .I_valid(valid),
        .O_ready(ready),
        .I_op(op),
        .I_word(word),
        .I_src1(s1),
        .I_src2(s2),
        .I_flush(flush),
        .O_out_valid(out_valid),
        .I_out_ready(out_ready),
        .O_result(result),
        .O_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called between edges with the unit idle; accept happens on the next rising edge
    task automatic run_op(input string tag, input logic [4:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat);
        int k;
        op = o; word = w; s1 = a; s2 = b; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 200);
        chk({tag, " latency"}, 64'(k), 64'(lat));
        chk({tag, " result"}, result, exp);
        if (out_ready) begin
            @(negedge clk);
            chk({tag, " ready after"}, 64'(ready), 64'(1));
        end
    endtask

    initial begin
        logic seen;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset result", result, 64'h0);
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset ready", 64'(ready), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul 3x5", MUL, 1'b0, 64'd3, 64'd5, 64'd15, 67);
        run_op("mul ffffffff^2", MUL, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 67);
        run_op("mulw sext", MUL, 1'b1, 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 35);
        run_op("divw -7/2", DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 35);
        run_op("remw -7/2", REM, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 35);
        run_op("divuw 16/3", DIVU, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd3, 64'd5, 35);
        run_op("div -100/7", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 67);
        run_op("rem -100/7", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 67);
        run_op("divu 100/0", DIVU, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run_op("remu 100/0", REMU, 1'b0, 64'd100, 64'd0, 64'd100, 2);
        run_op("div ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2);
        run_op("rem ovf", REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2);

        // Flush at cycle 20 of a 64-bit divide
        op = DIV; word = 1'b0; s1 = 64'd1000; s2 = 64'd3; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            seen |= out_valid;
            if (k == 20) flush = 1'b1;
        end
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        seen |= out_valid;
        chk("flush busy", 64'(busy), 64'(0));
        chk("flush ready", 64'(ready), 64'(1));
        chk("flush no out_valid", 64'(seen), 64'(0));
        run_op("mul 6x7 after flush", MUL, 1'b0, 64'd6, 64'd7, 64'd42, 67);

        // Flush together with a request in IDLE suppresses the accept
        op = MUL; s1 = 64'd2; s2 = 64'd2; valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("idle flush busy", 64'(busy), 64'(0));

        // Backpressure: result held while the consumer stalls
        out_ready = 1'b0;
        run_op("divu 1000/3", DIVU, 1'b0, 64'd1000, 64'd3, 64'd333, 67);
        repeat (10) @(negedge clk);
        chk("stall out_valid", 64'(out_valid), 64'(1));
        chk("stall result", result, 64'd333);
        chk("stall ready", 64'(ready), 64'(0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("consume out_valid", 64'(out_valid), 64'(0));
        chk("consume ready", 64'(ready), 64'(1));
        @(negedge clk);

        // Reset in the middle of CALC
        op = MUL; word = 1'b0; s1 = 64'd9; s2 = 64'd9; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("calc busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid reset out_valid", 64'(out_valid), 64'(0));
        chk("mid reset result", result, 64'h0);
        chk("mid reset busy", 64'(busy), 64'(0));
        chk("mid reset ready", 64'(ready), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
